// File: rtl/alu_pkg.sv
// Shared types for the ALU issue/capture stage: opcodes, sequencer states,
// the captured response record and the per-opcode settling latency.
package alu_pkg;

  localparam int DATA_W = 16;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'b0000,
    ALU_SUB  = 4'b0001,
    ALU_AND  = 4'b0010,
    ALU_NOT  = 4'b0011,
    ALU_OR   = 4'b0100,
    ALU_XOR  = 4'b0101,
    ALU_SHL  = 4'b0110,
    ALU_SHR  = 4'b0111,
    ALU_MUL  = 4'b1000,
    ALU_DIV  = 4'b1001,
    ALU_LOG  = 4'b1010,
    ALU_SQRT = 4'b1011
  } alu_op_e;

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } seq_state_e;

  typedef struct packed {
    logic [DATA_W-1:0] result;
    logic [DATA_W-1:0] result_x;
    logic [3:0]        op;
    logic              err;
  } alu_rsp_t;

  // Codes 1100-1111 are not ALU operations and settle like the simple ops.
  function automatic logic [7:0] op_latency(input logic [3:0] op,
                                            input int lat_simple, input int lat_mul,
                                            input int lat_div, input int lat_log,
                                            input int lat_sqrt);
    case (op)
      ALU_MUL:  op_latency = 8'(lat_mul);
      ALU_DIV:  op_latency = 8'(lat_div);
      ALU_LOG:  op_latency = 8'(lat_log);
      ALU_SQRT: op_latency = 8'(lat_sqrt);
      default:  op_latency = 8'(lat_simple);
    endcase
  endfunction

endpackage

// File: rtl/alu_rsp_fifo.sv
// Synchronous FIFO of captured ALU responses; any DEPTH >= 2, pointers wrap
// explicitly so non-power-of-two depths work.
module alu_rsp_fifo
  import alu_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic     clk,
  input  logic     rst,
  input  logic     push,
  input  alu_rsp_t wr_data,
  input  logic     pop,
  output alu_rsp_t rd_data,
  output logic     valid,
  output logic     full
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  alu_rsp_t        mem [DEPTH];
  logic [PW-1:0]   rd_ptr;
  logic [PW-1:0]   wr_ptr;
  logic [CW-1:0]   count;
  logic            do_push;
  logic            do_pop;

  assign valid   = (count != '0);
  assign full    = (count == CW'(DEPTH));
  assign do_pop  = pop && valid;
  assign do_push = push && !full;
  assign rd_data = mem[rd_ptr];

  function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
    ptr_next = (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= wr_data;
        wr_ptr      <= ptr_next(wr_ptr);
      end
      if (do_pop) rd_ptr <= ptr_next(rd_ptr);
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/alu_op_sequencer.sv
// Issue/capture stage around a combinational ALU: registers one command onto
// the ALU inputs, waits its settling latency, then captures into a FIFO.
module alu_op_sequencer
  import alu_pkg::*;
#(
  parameter int DATA_W     = 16,
  parameter int LAT_SIMPLE = 0,
  parameter int LAT_MUL    = 2,
  parameter int LAT_DIV    = 4,
  parameter int LAT_LOG    = 4,
  parameter int LAT_SQRT   = 4,
  parameter int FIFO_DEPTH = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_a,
  input  logic [DATA_W-1:0] in_b,
  input  logic [3:0]        in_op,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic [3:0]        alu_control,
  input  logic [DATA_W-1:0] alu_result,
  input  logic [DATA_W-1:0] alu_result_x,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_result,
  output logic [DATA_W-1:0] out_result_x,
  output logic [3:0]        out_op,
  output logic              out_err,
  output logic              busy
);

  // Both ports use valid/ready: a transfer happens on a rising edge where
  // valid && ready; in_ready never depends on in_valid, out_valid never on out_ready.

  seq_state_e state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic       err_q, err_d;
  logic       accept;
  logic       push;
  logic       fifo_full;
  alu_rsp_t   push_rsp;
  alu_rsp_t   head_rsp;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    err_d    = err_q;
    in_ready = 1'b0;
    accept   = 1'b0;
    push     = 1'b0;
    case (state_q)
      IDLE: begin
        in_ready = !fifo_full;
        if (in_valid && !fifo_full) begin
          accept  = 1'b1;
          cnt_d   = op_latency(in_op, LAT_SIMPLE, LAT_MUL, LAT_DIV, LAT_LOG, LAT_SQRT);
          err_d   = (in_op >= 4'b1100) || ((in_op == ALU_DIV) && (in_b == '0));
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (cnt_q != 8'd0) begin
          cnt_d = cnt_q - 8'd1;
        end else begin
          push    = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= 8'd0;
      err_q       <= 1'b0;
      alu_a       <= '0;
      alu_b       <= '0;
      alu_control <= 4'b0000;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      if (accept) begin
        alu_a       <= in_a;
        alu_b       <= in_b;
        alu_control <= in_op;
      end
    end
  end

  // The ALU leaves result_X undriven for codes 1100-1111, so it is zeroed here.
  assign push_rsp.result   = alu_result;
  assign push_rsp.result_x = (alu_control >= 4'b1100) ? '0 : alu_result_x;
  assign push_rsp.op       = alu_control;
  assign push_rsp.err      = err_q;

  alu_rsp_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push    (push),
    .wr_data (push_rsp),
    .pop     (out_ready),
    .rd_data (head_rsp),
    .valid   (out_valid),
    .full    (fifo_full)
  );

  assign out_result   = head_rsp.result;
  assign out_result_x = head_rsp.result_x;
  assign out_op       = head_rsp.op;
  assign out_err      = head_rsp.err;
  assign busy         = (state_q != IDLE);

endmodule

// File: doc/alu_op_sequencer.md
Name: alu_op_sequencer

Overview:
- Issue and capture stage placed directly around the combinational ALU.
- Accepts operation commands over a valid/ready handshake and registers the operands onto the ALU inputs.
- Waits a per-opcode settling latency so that the multiply, divide, log and sqrt paths can be multicycle paths.
- Captures result/result_X into an output FIFO that is drained over a valid/ready handshake.

Parameters:
- DATA_W, 16: operand and result width.
- LAT_SIMPLE, 0: extra wait cycles for ops 0000-0111.
- LAT_MUL, 2: extra wait cycles for op 1000.
- LAT_DIV, 4: extra wait cycles for op 1001.
- LAT_LOG, 4: extra wait cycles for op 1010.
- LAT_SQRT, 4: extra wait cycles for op 1011.
- FIFO_DEPTH, 2: output FIFO entries. Must be 2 or more.

Ports:
- clk  in  1  single clock; all state on rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  command valid.
- in_ready  out  1  command accepted on a cycle where in_valid && in_ready.
- in_a  in  DATA_W  operand A.
- in_b  in  DATA_W  operand B.
- in_op  in  4  ALU control code.
- alu_a  out  DATA_W  registered operand driven to ALU A.
- alu_b  out  DATA_W  registered operand driven to ALU B.
- alu_control  out  4  registered opcode driven to ALU control.
- alu_result  in  DATA_W  ALU result.
- alu_result_x  in  DATA_W  ALU result_X.
- out_valid  out  1  FIFO head valid.
- out_ready  in  1  consumer ready; pop on out_valid && out_ready.
- out_result  out  DATA_W  captured result.
- out_result_x  out  DATA_W  captured result_X.
- out_op  out  4  opcode of the captured entry.
- out_err  out  1  error flag of the captured entry.
- busy  out  1  high while state is not IDLE.

Behaviour:
- Reset values: all outputs 0 except in_ready. in_ready is 1 after rst deassertion because the FIFO is empty. FSM goes to IDLE, wait counter 0, FIFO emptied.
- FSM states: IDLE and WAIT.
- IDLE:
  - in_ready = (fifo_count < FIFO_DEPTH).
  - On accept: latch in_a, in_b and in_op into alu_a, alu_b and alu_control.
  - Load the counter with LAT(op), latch the error flag, then go to WAIT.
- WAIT:
  - in_ready = 0.
  - If counter != 0, decrement.
  - If counter == 0, push {alu_result, result_x_sel, alu_control, err} into the FIFO and return to IDLE.
- Latency: accept at edge N, push at edge N+1+LAT(op). out_valid rises at that edge if the FIFO was empty; otherwise the entry queues behind the existing ones.
- Throughput: one command per LAT(op)+2 cycles. There is no overlap; a single command is in flight.
- FIFO space is checked at accept time, so a push never hits a full FIFO.
- Simultaneous push and pop: count unchanged, order preserved.
- alu_a, alu_b and alu_control hold their last values while IDLE.
- LAT mapping: op 0000-0111 and op 1100-1111 use LAT_SIMPLE; 1000 uses LAT_MUL; 1001 uses LAT_DIV; 1010 uses LAT_LOG; 1011 uses LAT_SQRT.
- err = 1 if op >= 1100, or if op == 1001 and in_b == 0.
- result_x_sel:
  - Forced to 0 for op >= 1100, because the ALU leaves result_X undriven in its default case.
  - For every other op it is alu_result_x unchanged.
- alu_result is captured unchanged for all ops, including divide-by-zero.
- out_* fields come from the FIFO head and stay stable while out_valid && !out_ready.
- Reset mid-operation: the in-flight command and all FIFO contents are discarded. Nothing is emitted after reset release.

Decomposition:
- alu_pkg holds:
  - DATA_W.
  - typedef enum logic [3:0] alu_op_e: ALU_ADD, ALU_SUB, ALU_AND, ALU_NOT, ALU_OR, ALU_XOR, ALU_SHL, ALU_SHR, ALU_MUL, ALU_DIV, ALU_LOG, ALU_SQRT.
  - struct alu_rsp_t {result, result_x, op, err}.
  - Function op_latency.
- One sub-module: alu_rsp_fifo, a synchronous FIFO of alu_rsp_t with parameter DEPTH and async active-high reset.

Test Plan:
- ADD, LAT_SIMPLE=0, A=0x1234, B=0x0001, out_ready=1, accept at edge N -> out_valid=1 after edge N+1; out_result=0x1235, out_result_x=0, out_op=0000, out_err=0.
- MUL, A=0x0100, B=0x0100, LAT_MUL=2 -> out_valid after edge N+3; out_result=0x0000, out_result_x=0x0001, busy high for 3 cycles.
- DIV, A=0x0010, B=0x0000 -> out_err=1, out_op=1001. Then DIV with A=0x0011, B=0x0004 -> out_result=0x0004, out_result_x=0x0001, out_err=0.
- Illegal op 1110, A=3, B=4 -> out_result=0x0007, out_result_x=0x0000, out_err=1.
- Backpressure, out_ready=0, three ADDs (1+1, 2+2, 3+3):
  - Two are accepted; in_ready stays 0 with the FIFO full.
  - Set out_ready=1 -> outputs 2, 4, 6 in order.
  - The third command is accepted once the first pop frees space.
- Reset during WAIT of a DIV -> out_valid=0 and busy=0 immediately. After release: in_ready=1, alu_* = 0, no result is ever emitted.
